// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scan-code tracker slice.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam int         CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_GAP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ps2_byte_fetch.sv
// Pops bytes from the receiver FIFO: one byte per 3 cycles, single-cycle active-low pop.
module ps2_byte_fetch
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  output logic       kb_read_n,
  output logic       byte_vld,
  output logic [7:0] byte_data
);

  fetch_state_e state_r, state_s;
  logic         read_n_r;

  // Next-state logic for the fetch sequence
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (kb_ready) begin
          state_s = S_POP;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_POP:   state_s = S_GAP;
      S_GAP:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register and registered pop strobe, low only while in S_POP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      read_n_r <= 1'b1;
    end else begin
      state_r  <= state_s;
      read_n_r <= (state_s != S_POP);
    end
  end

  // The head byte is consumed at the same edge that launches the pop
  assign byte_vld  = (state_r == S_IDLE) && kb_ready;
  assign byte_data = kb_data;
  assign kb_read_n = read_n_r;

endmodule

// File: rtl/ps2_scancode_tracker.sv
// Decodes make/break/typematic scan-code sequences into held key, valid flag and press count.
// Optional E0 extended-set tracking is enabled by defining SCAN_EXT_EN.
module ps2_scancode_tracker
  import ps2_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter bit IGNORE_REPEAT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  input  logic             kb_overflow,
  output logic             kb_read_n,
  output logic [7:0]       key_code,
  output logic             key_valid,
  output logic             key_ext,
  output logic [CNT_W-1:0] key_count,
  output logic             ovf_seen
);

  logic             byte_vld_s;
  logic [7:0]       byte_data_s;
  logic             is_brk_s, is_ext_s, ext_eq_s, sel_code_s, hit_s, release_s, new_key_s;
  logic [7:0]       key_code_r;
  logic             key_valid_r, brk_pend_r, ovf_seen_r;
  logic [CNT_W-1:0] key_count_r;

  ps2_byte_fetch u_fetch (
    .clk       (clk),
    .rst       (rst),
    .kb_data   (kb_data),
    .kb_ready  (kb_ready),
    .kb_read_n (kb_read_n),
    .byte_vld  (byte_vld_s),
    .byte_data (byte_data_s)
  );

`ifdef SCAN_EXT_EN
  logic ext_pend_r, key_ext_r;
  assign is_ext_s = (byte_data_s == SC_EXT);
  assign ext_eq_s = (ext_pend_r == key_ext_r);
  assign key_ext  = key_ext_r;

  // E0 prefix tracking; cleared by any ordinary code, captured into key_ext on a new key
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_pend_r <= 1'b0;
      key_ext_r  <= 1'b0;
    end else begin
      if (byte_vld_s && !is_brk_s && is_ext_s) begin
        ext_pend_r <= 1'b1;
      end else if (sel_code_s) begin
        ext_pend_r <= 1'b0;
      end
      if (new_key_s) begin
        key_ext_r <= ext_pend_r;
      end
    end
  end
`else
  assign is_ext_s = 1'b0;
  assign ext_eq_s = 1'b1;
  assign key_ext  = 1'b0;
`endif

  assign is_brk_s   = (byte_data_s == SC_BREAK);
  assign sel_code_s = byte_vld_s && !is_brk_s && !is_ext_s;
  assign hit_s      = key_valid_r && (byte_data_s == key_code_r) && ext_eq_s;
  assign release_s  = sel_code_s && brk_pend_r && hit_s;
  assign new_key_s  = sel_code_s && !brk_pend_r && !(hit_s && IGNORE_REPEAT);

  // Key state, press counter and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk_pend_r  <= 1'b0;
      key_code_r  <= 8'h00;
      key_valid_r <= 1'b0;
      key_count_r <= '0;
      ovf_seen_r  <= 1'b0;
    end else begin
      if (byte_vld_s && is_brk_s) begin
        brk_pend_r <= 1'b1;
      end else if (sel_code_s) begin
        brk_pend_r <= 1'b0;
      end
      if (release_s) begin
        key_valid_r <= 1'b0;
      end else if (new_key_s) begin
        key_valid_r <= 1'b1;
        key_code_r  <= byte_data_s;
        key_count_r <= key_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      ovf_seen_r <= ovf_seen_r | kb_overflow;
    end
  end

  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_count = key_count_r;
  assign ovf_seen  = ovf_seen_r;

endmodule

// File: doc/ps2_scancode_tracker.md
Name: ps2_scancode_tracker

Overview:
- Consumer stage directly downstream of the PS/2 keyboard receiver FIFO.
- Pops received scan-code bytes through the FIFO's ready/read_n handshake.
- Decodes make, break (F0 prefix) and typematic-repeat sequences.
- Presents the currently held key, a key-valid flag and a press counter to the display path; the seven-segment decoders blank on key_valid=0.

Parameters:
- CNT_W, 8: width of the press counter; counter wraps modulo 2^CNT_W.
- IGNORE_REPEAT, 1: when 1, a make code equal to the currently held key is a typematic repeat and does not increment the counter; when 0, every make code increments it.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- kb_data  in  8  FIFO head byte; valid while kb_ready=1.
- kb_ready  in  1  FIFO non-empty.
- kb_overflow  in  1  FIFO overflow indication from receiver.
- kb_read_n  out  1  active-low pop strobe, exactly one cycle wide per consumed byte.
- key_code  out  8  scan code of the currently/last held key.
- key_valid  out  1  1 while a key is held.
- key_ext  out  1  key_code belongs to the E0 extended set (0 when SCAN_EXT_EN is undefined).
- key_count  out  CNT_W  number of distinct key presses since reset.
- ovf_seen  out  1  sticky: FIFO overflow occurred since reset.

Behaviour:
- Reset values: kb_read_n=1, key_code=0, key_valid=0, key_ext=0, key_count=0, ovf_seen=0, brk_pend=0, ext_pend=0, fetch FSM in S_IDLE.
- Reset mid-operation (including during S_POP) aborts the pop. No partial byte is processed.
- Fetch FSM: S_IDLE -> S_POP -> S_GAP -> S_IDLE.
  - S_IDLE: if kb_ready=1, sample kb_data, process the byte (rules below), drive kb_read_n=0 next cycle, go to S_POP.
  - S_POP: kb_read_n=0 for this cycle only; go to S_GAP.
  - S_GAP: kb_read_n=1; one settle cycle for FIFO pointer/data update; go to S_IDLE.
- Throughput: at most one byte per 3 cycles. kb_read_n is never low while kb_ready=0 at the time of sampling.
- Byte processing, in priority order:
  - 8'hF0: brk_pend<=1.
  - 8'hE0 (SCAN_EXT_EN only): ext_pend<=1.
  - Other byte with brk_pend=1 (break): if key_valid and byte==key_code and ext_pend==key_ext, then key_valid<=0; otherwise the break is ignored. Always clear brk_pend and ext_pend.
  - Other byte with brk_pend=0 (make): if key_valid and byte==key_code and ext_pend==key_ext and IGNORE_REPEAT=1, it is a repeat and no output changes. Otherwise key_code<=byte, key_ext<=ext_pend, key_valid<=1, key_count<=key_count+1. Clear ext_pend.
- Outputs update the cycle after the S_IDLE sampling edge (1-cycle latency byte->output).
- Single-key tracking: a second make while a key is held replaces key_code and counts. A break for the older key is then ignored.
- Counter wrap: 2^CNT_W-1 + 1 -> 0, no flag.
- Prefix collisions:
  - F0 F0: second F0 keeps brk_pend=1.
  - E0 after F0: sets ext_pend, and brk_pend stays set.
- ovf_seen <= 1 on any cycle with kb_overflow=1, in any FSM state. Cleared only by rst.

Optional Feature:
- Macro SCAN_EXT_EN.
- Defined: E0 prefix handled as above; key_ext reflects the prefix.
- Undefined: 8'hE0 is treated as an ordinary make/break code; ext_pend logic is absent; key_ext is tied to 0.

Decomposition:
- Shared package ps2_pkg holds:
  - SC_BREAK=8'hF0 and SC_EXT=8'hE0.
  - Fetch-state typedef (S_IDLE, S_POP, S_GAP).
  - Default CNT_W.
- One natural sub-module: ps2_byte_fetch. It contains the fetch FSM and handshake, and emits a 1-cycle byte_vld with byte_data to the decode logic.

Test Plan:
- Reset then 1C, F0, 1C -> after 1C: key_code=8'h1C, key_valid=1, key_count=1; after F0 1C: key_valid=0, key_count=1; exactly 3 kb_read_n low pulses.
- 1C, 1C, 1C (typematic), then F0 1C, IGNORE_REPEAT=1 -> key_count=1, key_valid=0; with IGNORE_REPEAT=0 -> key_count=3.
- 1C, 32, F0 1C, F0 32 -> key_count=2; after F0 1C: key_code=8'h32, key_valid=1; after F0 32: key_valid=0.
- SCAN_EXT_EN: E0 75, E0 F0 75 -> key_code=8'h75, key_ext=1, key_valid=1, then key_valid=0. Mixed case 75 then E0 F0 75 -> key_valid stays 1.
- 256 distinct make/break pairs with CNT_W=8 -> key_count wraps to 0. A kb_overflow pulse mid-stream -> ovf_seen=1 and held until rst.
- Assert rst during S_POP -> kb_read_n=1 immediately, all outputs 0. After release with kb_ready=1, the next byte is processed normally.
